rf_write_arbiter: RTL
=====================

# rf_write_arbiter

Round-robin arbiter that shares the single write port of the 32x32 register file among NREQ requesters and sequences it against read cycles. The register file performs reads only in cycles where its write enable is low, so this block grants reads or writes cycle by cycle and holds writes off while reads are requested. A starvation counter bounds how long pending writes can be held off. It sits directly in front of the register file's A3/WD3/WE3 inputs and drives the read-slot grant to the read sequencer.

## Interface
- NREQ, 4, number of write requesters (2..8)
- AW, 5, register address width
- DW, 32, data width
- MAXHOLD, 4, consecutive stalled cycles before writes force priority over reads (1..15)

- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous active-high reset
- req_valid  input  NREQ  requester i has a write pending
- req_addr  input  NREQ*AW  requester i address in bits [i*AW +: AW]
- req_data  input  NREQ*DW  requester i data in bits [i*DW +: DW]
- req_ready  output  NREQ  one-hot combinational grant; write i accepted when req_valid[i] & req_ready[i]
- rd_req  input  1  read sequencer wants the next register-file cycle for reads
- rd_grant  output  1  combinational; register file cycle after this one is a read cycle (rf_we=0)
- rf_we  output  1  registered, to WE3
- rf_waddr  output  AW  registered, to A3
- rf_wdata  output  DW  registered, to WD3
- wr_count  output  16  registered count of writes issued to the register file, wraps at 2^16

## Operation
- State: rr_ptr (last granted index), hold_cnt (4 bits), output register (rf_we, rf_waddr, rf_wdata), wr_count.
- force_wr = (hold_cnt >= MAXHOLD).
- Write slot open when !rd_req | force_wr.
- When write slot open and any req_valid: grant exactly one requester, searching from (rr_ptr+1) mod NREQ upward with wrap; req_ready has that single bit set. rr_ptr updates to the granted index.
- req_ready is all-zero when no slot is open or no req_valid is set; req_ready never asserts for an invalid requester.
- rd_grant = rd_req & !(force_wr & |req_valid).
- hold_cnt: increments (saturating at 15) in each cycle with |req_valid & rd_req & !force_wr; clears on any write grant; clears when req_valid is all-zero.
- Output register: on a grant, load rf_we=1 with the granted addr/data; otherwise rf_we=0, and rf_waddr/rf_wdata hold their values.
- wr_count increments in each cycle where rf_we=1.

## Timing
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, wr_count=0, hold_cnt=0, rr_ptr=NREQ-1, so requester 0 has first priority.
- Latency: a write accepted in cycle T appears on rf_we/rf_waddr/rf_wdata in T+1. The register file commits it at the end of T+1.
- Throughput: one write per cycle. The output stage never stalls.
- Read and write are mutually exclusive: rd_grant and |req_ready are never both high.
- With rd_req high continuously and writes pending, writes are blocked for MAXHOLD cycles, then exactly one write is granted. The counter then clears and the pattern repeats.
- Requester deasserting req_valid without a grant is legal; no state is kept for it.
- Reset asserted mid-operation clears the output register immediately (asynchronously). A write accepted in the cycle before reset is lost and is not counted.

## Configuration
- RF_ARB_X0_DROP_EN defined: an accepted write with address 0 is handshaken normally (req_ready, rr_ptr update, hold_cnt clear). rf_we stays 0 in T+1 and wr_count does not increment; rf_waddr/rf_wdata still load.
- Not defined: address 0 is written like any other address.

## Test plan
- Reset: assert rst mid-run with pending write -> rf_we=0, wr_count=0 immediately; first post-reset grant goes to req 0 when all four requesters are valid.
- Round robin: all four req_valid held, rd_req=0 -> grants 0,1,2,3,0; rf_waddr follows one cycle later; wr_count=5 after the fifth write cycle.
- Latency: req 2 valid with addr 7, data 0xDEADBEEF at T -> rf_we=1, rf_waddr=7, rf_wdata=0xDEADBEEF at T+1 only.
- Starvation: rd_req=1 held, req 1 valid -> rd_grant=1 for 4 cycles, then req_ready[1]=1 with rd_grant=0 for one cycle, then reads resume.
- Mutual exclusion: random req_valid/rd_req for 10k cycles -> never rd_grant & |req_ready; req_ready is always one-hot or zero and subset of req_valid.
- X0 drop: write addr 0 data 0x1234 -> with RF_ARB_X0_DROP_EN, req_ready=1, rf_we=0 at T+1, wr_count unchanged; without the macro, rf_we=1 and wr_count increments by 1.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin arbiter sharing the register-file write port among NREQ requesters, interleaved with reads
// Ports: clk, rst (async, active high); req_valid/req_addr/req_data in, req_ready out (one-hot grant);
// rd_req in, rd_grant out (next cycle is a read cycle); rf_we/rf_waddr/rf_wdata registered to WE3/A3/WD3;
// wr_count counts issued writes. Optional RF_ARB_X0_DROP_EN: handshake writes to address 0 but never issue them.
module rf_write_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 5,
  parameter int DW      = 32,
  parameter int MAXHOLD = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 rd_req,
  output logic                 rd_grant,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_waddr,
  output logic [DW-1:0]        rf_wdata,
  output logic [15:0]          wr_count
);
  localparam int PW = $clog2(NREQ);
  logic [PW-1:0] rr_ptr, gnt_idx, idx;
  logic [3:0]    hold_cnt;
  logic          found, force_wr, grant, we_n;
  logic [AW-1:0] gaddr;
  always_comb begin
    gnt_idx = rr_ptr;
    found   = 1'b0;
    idx     = rr_ptr;
    for (int k = 1; k <= NREQ; k++) begin
      idx = PW'((int'(rr_ptr) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
  end
  assign force_wr  = hold_cnt >= 4'(MAXHOLD);
  assign grant     = found & (!rd_req | force_wr);
  assign req_ready = grant ? NREQ'(1) << gnt_idx : '0;
  assign rd_grant  = rd_req & !(force_wr & |req_valid);
  assign gaddr     = req_addr[gnt_idx*AW +: AW];
`ifdef RF_ARB_X0_DROP_EN
  assign we_n = grant & |gaddr;
`else
  assign we_n = grant;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= PW'(NREQ-1);
      hold_cnt <= 4'd0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      wr_count <= '0;
    end else begin
      rf_we    <= we_n;
      wr_count <= wr_count + 16'(rf_we);
      hold_cnt <= (grant | ~|req_valid) ? 4'd0 :
                  (rd_req & !force_wr & hold_cnt != 4'd15) ? hold_cnt + 4'd1 : hold_cnt;
      if (grant) begin
        rr_ptr   <= gnt_idx;
        rf_waddr <= gaddr;
        rf_wdata <= req_data[gnt_idx*DW +: DW];
      end
    end
  end
endmodule
